// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Central hazard/stall controller for the 5-stage core (IF, ID, EX, MEM, WB).
// Every inter-stage pipeline register k takes stall[k] as its own hold and
// stall[k+1] as the hold of the stage it feeds. A stall request from stage s
// therefore freezes every stage from IF up to s and lets a bubble into s+1.
//
// MEM-stage exceptions (and ERET) are sequenced through a small FSM. If the
// exception arrives while a data-cache miss is in flight, the FSM waits for
// the miss to finish. Only then does it issue the one-cycle flush/redirect.
// A redirect therefore never overtakes an outstanding memory access.
//
// Optional feature (macro PIPELINE_STALL_PERF_EN):
//   defined   : stall_cycles / flush_count performance counters are built.
//   undefined : both counter outputs are constant 0 and no counter flops exist.
//
// Parameters
//   ADDR_WIDTH   width of the redirect target PC
//   CNT_WIDTH    width of the performance counters
//
// Ports
//   clk             in   core clock, rising edge
//   rst             in   asynchronous reset, active-high
//   req_if          in   fetch stall request (I-cache miss)
//   req_id          in   decode stall request (load-use hazard)
//   req_ex          in   execute stall request (mul/div busy)
//   req_mem         in   memory stall request (D-cache miss / uncached)
//   exc_valid       in   exception/ERET committed at MEM (1-cycle pulse)
//   exc_target      in   redirect PC, qualified by exc_valid
//   stall[4:0]      out  per-stage hold, bit0=IF .. bit4=WB (combinational)
//   flush           out  clear all stage registers IF..MEM (registered)
//   redirect_valid  out  PC redirect strobe to fetch (registered)
//   redirect_pc     out  redirect PC (registered, 0 when not redirecting)
//   stall_cycles    out  cycles with IF held, excluding flush cycles
//   flush_count     out  number of flush cycles issued
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_if,
  input  logic                  req_id,
  input  logic                  req_ex,
  input  logic                  req_mem,
  input  logic                  exc_valid,
  input  logic [ADDR_WIDTH-1:0] exc_target,
  output logic [4:0]            stall,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic                  flush_q, flush_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [4:0]            stall_req;

  // ---------------------------------------------------------------------------
  // Stall priority: the highest-index requesting stage s holds stages 0..s.
  // WB (bit 4) is never held.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if-chain can leave it unassigned and infer a latch.
    stall_req = 5'b00000;
    if (req_mem) begin
      stall_req = 5'b01111;
    end else if (req_ex) begin
      stall_req = 5'b00111;
    end else if (req_id) begin
      stall_req = 5'b00011;
    end else if (req_if) begin
      stall_req = 5'b00001;
    end
  end

  // The flush cycle empties IF..MEM, so holding anything then is meaningless;
  // reset also forces the vector low without waiting for a clock edge.
  assign stall = (rst || (state_q == FLUSH)) ? 5'b00000 : stall_req;

  // ---------------------------------------------------------------------------
  // Exception sequencing FSM: next state and registered-output next values.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    target_d = target_q;

    unique case (state_q)
      IDLE: begin
        if (exc_valid) begin
          target_d = exc_target;
          // An in-flight D-cache miss must drain before the redirect.
          state_d  = req_mem ? WAIT_MEM : FLUSH;
        end
      end
      WAIT_MEM: begin
        // exc_valid is ignored here: the pending flush will kill MEM anyway.
        if (!req_mem) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The strobes are registered copies of "entering FLUSH", so they are
    // high for exactly the one cycle the FSM spends in FLUSH.
    flush_d       = (state_d == FLUSH);
    redirect_pc_d = flush_d ? target_d : '0;
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      target_q      <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = flush_q;
  assign redirect_pc    = redirect_pc_q;

  // ---------------------------------------------------------------------------
  // Performance counters (optional). Both wrap naturally at 2^CNT_WIDTH.
  // ---------------------------------------------------------------------------
`ifdef PIPELINE_STALL_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall[0] && (state_q != FLUSH)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (flush_q) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central hazard/stall controller for the 5-stage core: IF, ID, EX, MEM, WB.
- Collects per-stage stall requests and MEM-stage exception redirects.
- Drives the per-stage stall vector consumed by every inter-stage pipeline register. Register k receives stall[k] as its current-stage stall and stall[k+1] as its next-stage stall.
- Sequences exception flushes through a small FSM so a redirect never overtakes an in-flight data-cache miss.

Parameters:
- ADDR_WIDTH, 32, width of redirect target PC.
- CNT_WIDTH, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_if  input  1  fetch stall request (I-cache miss).
- req_id  input  1  decode stall request (load-use hazard).
- req_ex  input  1  execute stall request (multi-cycle mul/div busy).
- req_mem  input  1  memory stall request (D-cache miss / uncached access).
- exc_valid  input  1  exception or ERET committed at MEM, 1-cycle pulse.
- exc_target  input  ADDR_WIDTH  redirect PC, valid with exc_valid.
- stall  output  5  bit0=IF … bit4=WB; 1 = hold that stage.
- flush  output  1  clear all stage registers IF..MEM.
- redirect_valid  output  1  PC redirect strobe to fetch.
- redirect_pc  output  ADDR_WIDTH  redirect PC.
- stall_cycles  output  CNT_WIDTH  performance counter (optional feature).
- flush_count  output  CNT_WIDTH  performance counter (optional feature).

Behaviour:
- Reset (rst=1, async): FSM=IDLE, pending target=0, flush=0, redirect_valid=0, redirect_pc=0, counters=0. stall is combinational from the inputs and equals 5'b0 while rst=1.
- Stall priority:
  - s = highest-index stage asserting a request (MEM=3 > EX=2 > ID=1 > IF=0).
  - stall[0..s]=1; stall[s+1..4]=0.
  - No requests → stall=0. WB (bit4) is never stalled.
  - Example: req_id=1 only → stall=5'b00011, so a bubble enters EX.
  - req_if=1 and req_mem=1 together → 5'b01111.
  - stall is combinational from the requests with zero latency.
- FSM states IDLE, WAIT_MEM, FLUSH:
  - IDLE, exc_valid=1 and req_mem=0 → latch exc_target, go to FLUSH.
  - IDLE, exc_valid=1 and req_mem=1 → latch exc_target, go to WAIT_MEM.
  - WAIT_MEM: stall follows the normal priority rule; exc_valid is ignored. When req_mem falls to 0 → FLUSH.
  - FLUSH: lasts exactly 1 cycle, registered outputs. flush=1, redirect_valid=1, redirect_pc=latched target. stall is forced to 5'b0 regardless of requests. Next state IDLE.
  - exc_valid in FLUSH or WAIT_MEM is dropped; MEM is flushed, so no second valid exception can exist.
- Latency: exc_valid sampled at edge N → flush/redirect high during cycle N+1 when req_mem=0.
- Simultaneous exc_valid and req_ex/req_id in IDLE: the exception still goes to FLUSH next cycle. The stall vector that cycle follows the requests.
- Reset asserted mid-WAIT_MEM or mid-FLUSH → immediate return to IDLE with outputs cleared; the pending redirect is lost.
- flush and redirect_valid are never asserted for more than one consecutive cycle per exception.

Optional Feature:
- Macro: PIPELINE_STALL_PERF_EN.
- Defined:
  - stall_cycles increments every cycle with stall[0]=1 and FSM≠FLUSH.
  - flush_count increments on every cycle flush=1.
  - Both counters wrap modulo 2^CNT_WIDTH and reset to 0.
- Undefined: both outputs are tied to constant 0 and no counter flops are built.

Test Plan:
- Reset/idle: rst pulse mid-cycle with no requests → all outputs 0 immediately. After release, stall=5'b00000.
- Priority: req_id=1 → 5'b00011; add req_ex=1 → 5'b00111; req_if=1 with req_mem=1 → 5'b01111; all requests deasserted → 0.
- Clean exception: exc_valid pulse with exc_target=32'hBFC00380, req_mem=0.
  - Next cycle only: flush=1, redirect_valid=1, redirect_pc=32'hBFC00380, stall=0.
  - Following cycle: all three back to 0.
- Exception during D-cache miss: req_mem held 1 for 4 cycles, exc_valid on cycle 1.
  - While req_mem=1: stall=5'b01111 and no flush.
  - flush pulses the cycle after req_mem drops.
  - A second exc_valid during the wait is ignored.
- Reset mid-operation: rst asserted during WAIT_MEM → no flush ever issued. After release, a new exc_valid behaves as in the clean-exception case.
- Perf (macro on): 10 cycles with req_id=1, then one exception → stall_cycles=10, flush_count=1. With the macro off, both outputs read 0.
